openmips_mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the CPU's instruction-fetch port and its data-memory port inside openmips_min_sopc.
- Grants one requester at a time and sequences a fixed-latency memory access.
- Returns read data with a one-cycle ack pulse and drives a stall request to the pipeline controller while any access is outstanding.
- Data port has priority, with bounded starvation of instruction fetch.

---
 rtl/openmips_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_openmips_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openmips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// openmips_mem_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// port (if_*) and the data-memory port (dm_*). One access is in flight at a
// time. Each access goes IDLE -> ISSUE -> (WAIT) -> RESP, so the ack comes
// MEM_LAT cycles after the memory strobe.
//
// The data port wins ties. After MAX_CONSEC back-to-back data grants made
// while a fetch was waiting, the fetch is granted next.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr    fetch request (level) and address
//   if_ack/if_rdata   fetch completion pulse and read data (held after ack)
//   dm_req/we/sel/    data request (level), write enable, byte enables,
//   dm_addr/wdata       address and write data
//   dm_ack/dm_rdata   data completion pulse and read data (unchanged on writes)
//   mem_*             memory strobe, write enable, byte enables, address,
//                       write data, and returned read data
//   stall_req         combinational pipeline stall while a request is open
//   busy              high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module openmips_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_CONSEC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_sel,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_ack,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_sel,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_req,
    output logic                busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] CONSEC_MAX = 4'(MAX_CONSEC);
    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);

    logic [1:0]          r_state;
    logic [3:0]          r_consec;
    logic [3:0]          r_lat;
    logic                r_gnt_dm;
    logic                r_if_ack;
    logic                r_dm_ack;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_mem_ce;
    logic                r_mem_we;
    logic [DATA_W/8-1:0] r_mem_sel;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic w_any_req;
    logic w_grant_dm;
    logic w_done;

    assign w_any_req  = if_req | dm_req;
    // Data wins unless a waiting fetch has already been passed over MAX_CONSEC times.
    assign w_grant_dm = dm_req & ~(if_req & (r_consec == CONSEC_MAX));
    // True in the last cycle before RESP: the edge ending it carries valid mem_rdata.
    assign w_done     = ((r_state == S_ISSUE) && (MEM_LAT == 1)) ||
                        ((r_state == S_WAIT) && (r_lat == 4'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_consec    <= '0;
            r_lat       <= '0;
            r_gnt_dm    <= 1'b0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_sel   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_ce <= 1'b0;
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= S_ISSUE;
                        r_mem_ce <= 1'b1;
                        r_gnt_dm <= w_grant_dm;
                        if (w_grant_dm) begin
                            r_mem_we    <= dm_we;
                            r_mem_sel   <= dm_sel;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                            // Only grants that make a fetch wait count toward starvation.
                            if (if_req) begin
                                r_consec <= (r_consec == CONSEC_MAX) ? r_consec : r_consec + 4'd1;
                            end else begin
                                r_consec <= '0;
                            end
                        end else begin
                            // Fetches are always full-word reads; write data is left as is.
                            r_mem_we   <= 1'b0;
                            r_mem_sel  <= '1;
                            r_mem_addr <= if_addr;
                            r_consec   <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (MEM_LAT == 1) begin
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_WAIT;
                        r_lat   <= LAT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (r_lat == 4'd1) begin
                        r_state <= S_RESP;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_done) begin
                if (r_gnt_dm) begin
                    r_dm_ack <= 1'b1;
                    if (!r_mem_we) begin
                        r_dm_rdata <= mem_rdata;
                    end
                end else begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_ack    = r_if_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_ack    = r_dm_ack;
    assign dm_rdata  = r_dm_rdata;
    assign mem_ce    = r_mem_ce;
    assign mem_we    = r_mem_we;
    assign mem_sel   = r_mem_sel;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);
    assign stall_req = (if_req & ~r_if_ack) | (dm_req & ~r_dm_ack);

endmodule

// File: tb/tb_openmips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for openmips_mem_arbiter.
// Instance A uses MEM_LAT=2 and instance B uses MEM_LAT=1. Both instances
// share the same request stimulus. Each instance has its own memory model,
// and that model drives valid read data only in the cycle where it must be
// sampled. Expected acks are queued when a request is raised. They are popped
// and compared when an ack appears.
// -----------------------------------------------------------------------------
module tb_openmips_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        logic        dm;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [SW-1:0] dm_sel = '0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;

    logic          a_if_ack, a_dm_ack, a_mem_ce, a_mem_we, a_stall, a_busy;
    logic [DW-1:0] a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
    logic [SW-1:0] a_mem_sel;
    logic [AW-1:0] a_mem_addr;
    logic          b_if_ack, b_dm_ack, b_mem_ce, b_mem_we, b_stall, b_busy;
    logic [DW-1:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
    logic [SW-1:0] b_mem_sel;
    logic [AW-1:0] b_mem_addr;

    logic [3:0] a_age;
    exp_t       q[$];
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic exp_t mk(input logic dm, input logic [31:0] d, input int c);
        exp_t e;
        e.dm = dm;
        e.data = d;
        e.cyc = c;
        return e;
    endfunction

    // The MEM_LAT=2 memory drives valid data only in the cycle after the strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst) a_age <= 4'd0;
        else if (a_mem_ce) a_age <= 4'd1;
        else if (a_age != 4'd0 && a_age != 4'hF) a_age <= a_age + 4'd1;
    end
    assign a_mem_rdata = (a_age == 4'd1) ? memval(a_mem_addr) : 32'hBAD0_BAD0;
    // The MEM_LAT=1 memory drives valid data only during the strobe cycle.
    assign b_mem_rdata = b_mem_ce ? memval(b_mem_addr) : 32'hBAD0_BAD0;

    openmips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .MAX_CONSEC(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
        .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_sel(a_mem_sel), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .stall_req(a_stall), .busy(a_busy)
    );

    openmips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_CONSEC(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_sel(b_mem_sel), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .stall_req(b_stall), .busy(b_busy)
    );

    // Resets both instances. On return the bench is 1 time unit after a rising edge;
    // that point is cycle 0.
    task automatic do_reset();
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_sel = '0; dm_addr = '0; dm_wdata = '0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", a_busy); else passed++;
        total++; if ({a_mem_ce, a_mem_we, a_if_ack, a_dm_ack} !== 4'b0) $display("FAIL reset_ctrl: got %b required 0000", {a_mem_ce, a_mem_we, a_if_ack, a_dm_ack}); else passed++;
        total++; if ({a_if_rdata, a_dm_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h %h required 0 0", a_if_rdata, a_dm_rdata); else passed++;
        total++; if ({a_mem_addr, a_mem_sel, a_mem_wdata} !== 68'h0) $display("FAIL reset_mem: got %h %h %h required 0", a_mem_addr, a_mem_sel, a_mem_wdata); else passed++;
        total++; if (a_stall !== 1'b0) $display("FAIL reset_stall: got %0b required 0", a_stall); else passed++;
    endtask

    task automatic test_fetch();
        exp_t e;
        logic drop_if;
        do_reset();
        drop_if = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        q.push_back(mk(1'b0, 32'hDEADBEEF, 3));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            total++; if (a_stall !== (k <= 2)) $display("FAIL fetch_stall: cycle %0d got %0b required %0b", k, a_stall, (k <= 2)); else passed++;
            total++; if (a_mem_ce !== (k == 1)) $display("FAIL fetch_mem_ce: cycle %0d got %0b required %0b", k, a_mem_ce, (k == 1)); else passed++;
            if (k == 1) begin
                total++; if ({a_mem_addr, a_mem_we, a_mem_sel} !== {32'h100, 1'b0, 4'hF}) $display("FAIL fetch_issue: got addr=%h we=%0b sel=%h required addr=100 we=0 sel=f", a_mem_addr, a_mem_we, a_mem_sel); else passed++;
            end
            if (k == 2) begin
                total++; if (a_mem_addr !== 32'h100) $display("FAIL fetch_addr_hold: got %h required 00000100", a_mem_addr); else passed++;
            end
            if (a_if_ack || a_dm_ack) begin
                total++;
                if (q.size() == 0) $display("FAIL fetch_ack: unexpected ack at cycle %0d, required none", k);
                else begin
                    e = q.pop_front();
                    if (a_dm_ack !== e.dm || a_if_ack !== !e.dm || (e.dm ? a_dm_rdata : a_if_rdata) !== e.data || k != e.cyc)
                        $display("FAIL fetch_ack: got dm=%0b data=%h cycle %0d, required dm=%0b data=%h cycle %0d", a_dm_ack, (e.dm ? a_dm_rdata : a_if_rdata), k, e.dm, e.data, e.cyc);
                    else passed++;
                end
                if (a_if_ack) drop_if = 1'b1;
            end
            @(posedge clk);
            #1;
            if (drop_if) if_req = 1'b0;
        end
        total++; if (q.size() != 0) $display("FAIL fetch_pending: got %0d outstanding acks required 0", q.size()); else passed++;
        total++; if (a_if_rdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata_hold: got %h required deadbeef", a_if_rdata); else passed++;
    endtask

    task automatic test_priority();
        exp_t e;
        logic drop_if, drop_dm;
        do_reset();
        drop_if = 1'b0; drop_dm = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h100;
        q.push_back(mk(1'b1, 32'h5A5A_0200, 3));
        q.push_back(mk(1'b0, 32'hDEADBEEF, 7));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (a_mem_ce !== (k == 1 || k == 5)) $display("FAIL prio_mem_ce: cycle %0d got %0b required %0b", k, a_mem_ce, (k == 1 || k == 5)); else passed++;
            if (k == 1) begin
                total++; if (a_mem_addr !== 32'h200) $display("FAIL prio_dm_addr: got %h required 00000200", a_mem_addr); else passed++;
            end
            if (k == 5) begin
                total++; if ({a_mem_addr, a_mem_we, a_mem_sel} !== {32'h100, 1'b0, 4'hF}) $display("FAIL prio_if_issue: got addr=%h we=%0b sel=%h required addr=100 we=0 sel=f", a_mem_addr, a_mem_we, a_mem_sel); else passed++;
            end
            if (a_if_ack || a_dm_ack) begin
                total++;
                if (q.size() == 0) $display("FAIL prio_ack: unexpected ack at cycle %0d, required none", k);
                else begin
                    e = q.pop_front();
                    if (a_dm_ack !== e.dm || a_if_ack !== !e.dm || (e.dm ? a_dm_rdata : a_if_rdata) !== e.data || k != e.cyc)
                        $display("FAIL prio_ack: got dm=%0b data=%h cycle %0d, required dm=%0b data=%h cycle %0d", a_dm_ack, (e.dm ? a_dm_rdata : a_if_rdata), k, e.dm, e.data, e.cyc);
                    else passed++;
                end
                if (a_if_ack) drop_if = 1'b1;
                if (a_dm_ack) drop_dm = 1'b1;
            end
            @(posedge clk);
            #1;
            if (drop_if) if_req = 1'b0;
            if (drop_dm) dm_req = 1'b0;
        end
        total++; if (q.size() != 0) $display("FAIL prio_pending: got %0d outstanding acks required 0", q.size()); else passed++;
    endtask

    task automatic test_starvation();
        exp_t e;
        logic drop_if;
        do_reset();
        drop_if = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h100;
        for (int i = 0; i < 4; i++) q.push_back(mk(1'b1, 32'h5A5A_0300, 3 + 4 * i));
        q.push_back(mk(1'b0, 32'hDEADBEEF, 19));
        q.push_back(mk(1'b1, 32'h5A5A_0300, 23));
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (a_if_ack || a_dm_ack) begin
                total++;
                if (q.size() == 0) $display("FAIL starve_ack: unexpected ack at cycle %0d, required none", k);
                else begin
                    e = q.pop_front();
                    if (a_dm_ack !== e.dm || a_if_ack !== !e.dm || (e.dm ? a_dm_rdata : a_if_rdata) !== e.data || k != e.cyc)
                        $display("FAIL starve_ack: got dm=%0b data=%h cycle %0d, required dm=%0b data=%h cycle %0d", a_dm_ack, (e.dm ? a_dm_rdata : a_if_rdata), k, e.dm, e.data, e.cyc);
                    else passed++;
                end
                if (a_if_ack) drop_if = 1'b1;
            end
            @(posedge clk);
            #1;
            if (drop_if) if_req = 1'b0;
        end
        total++; if (q.size() != 0) $display("FAIL starve_pending: got %0d outstanding acks required 0", q.size()); else passed++;
        dm_req = 1'b0;
    endtask

    task automatic test_write();
        exp_t e;
        int   nack;
        logic next_wr, drop_dm;
        do_reset();
        nack = 0; next_wr = 1'b0; drop_dm = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011; dm_wdata = 32'h12345678; dm_addr = 32'h40;
        q.push_back(mk(1'b1, 32'h0, 3));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (a_mem_ce !== (k == 1 || k == 5)) $display("FAIL write_mem_ce: cycle %0d got %0b required %0b", k, a_mem_ce, (k == 1 || k == 5)); else passed++;
            if (k == 1) begin
                total++; if ({a_mem_addr, a_mem_we, a_mem_sel, a_mem_wdata} !== {32'h40, 1'b1, 4'b0011, 32'h12345678}) $display("FAIL write_issue: got addr=%h we=%0b sel=%b wdata=%h required addr=40 we=1 sel=0011 wdata=12345678", a_mem_addr, a_mem_we, a_mem_sel, a_mem_wdata); else passed++;
            end
            if (k == 5) begin
                total++; if ({a_mem_addr, a_mem_we, a_mem_sel, a_mem_wdata} !== {32'h44, 1'b1, 4'b0000, 32'h0000ABCD}) $display("FAIL write_sel0_issue: got addr=%h we=%0b sel=%b wdata=%h required addr=44 we=1 sel=0000 wdata=0000abcd", a_mem_addr, a_mem_we, a_mem_sel, a_mem_wdata); else passed++;
            end
            if (a_if_ack || a_dm_ack) begin
                total++;
                if (q.size() == 0) $display("FAIL write_ack: unexpected ack at cycle %0d, required none", k);
                else begin
                    e = q.pop_front();
                    if (a_dm_ack !== e.dm || a_if_ack !== !e.dm || (e.dm ? a_dm_rdata : a_if_rdata) !== e.data || k != e.cyc)
                        $display("FAIL write_ack: got dm=%0b data=%h cycle %0d, required dm=%0b data=%h cycle %0d", a_dm_ack, (e.dm ? a_dm_rdata : a_if_rdata), k, e.dm, e.data, e.cyc);
                    else passed++;
                end
                if (a_dm_ack) begin
                    nack++;
                    if (nack == 1) next_wr = 1'b1;
                    else drop_dm = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (next_wr) begin
                next_wr = 1'b0;
                dm_sel = 4'b0000; dm_addr = 32'h44; dm_wdata = 32'h0000ABCD;
                q.push_back(mk(1'b1, 32'h0, k + 1 + 3));
            end
            if (drop_dm) dm_req = 1'b0;
        end
        total++; if (q.size() != 0) $display("FAIL write_pending: got %0d outstanding acks required 0", q.size()); else passed++;
    endtask

    task automatic test_lat1();
        exp_t e;
        int   nack;
        logic [31:0] next_addr;
        logic do_next, drop_if;
        do_reset();
        nack = 0; do_next = 1'b0; drop_if = 1'b0; next_addr = '0;
        if_req = 1'b1; if_addr = 32'h100;
        q.push_back(mk(1'b0, 32'hDEADBEEF, 2));
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            total++; if (b_mem_ce !== (k == 1 || k == 4 || k == 7)) $display("FAIL lat1_mem_ce: cycle %0d got %0b required %0b", k, b_mem_ce, (k == 1 || k == 4 || k == 7)); else passed++;
            if (b_if_ack || b_dm_ack) begin
                total++;
                if (q.size() == 0) $display("FAIL lat1_ack: unexpected ack at cycle %0d, required none", k);
                else begin
                    e = q.pop_front();
                    if (b_dm_ack !== e.dm || b_if_ack !== !e.dm || (e.dm ? b_dm_rdata : b_if_rdata) !== e.data || k != e.cyc)
                        $display("FAIL lat1_ack: got dm=%0b data=%h cycle %0d, required dm=%0b data=%h cycle %0d", b_dm_ack, (e.dm ? b_dm_rdata : b_if_rdata), k, e.dm, e.data, e.cyc);
                    else passed++;
                end
                if (b_if_ack) begin
                    nack++;
                    if (nack < 3) begin
                        do_next = 1'b1;
                        next_addr = 32'h100 + 32'(4 * nack);
                    end else drop_if = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (do_next) begin
                do_next = 1'b0;
                if_addr = next_addr;
                q.push_back(mk(1'b0, memval(next_addr), k + 1 + 2));
            end
            if (drop_if) if_req = 1'b0;
        end
        total++; if (q.size() != 0) $display("FAIL lat1_pending: got %0d outstanding acks required 0", q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic drop_dm;
        do_reset();
        drop_dm = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (a_mem_ce !== 1'b1) $display("FAIL rstmid_issue: got mem_ce=%0b required 1", a_mem_ce); else passed++;
        @(posedge clk);
        #1;
        total++; if (a_busy !== 1'b1) $display("FAIL rstmid_busy_wait: got %0b required 1", a_busy); else passed++;
        #2 rst = 1'b0;
        if_req = 1'b0;
        #1;
        total++; if ({a_busy, a_mem_ce, a_if_ack, a_dm_ack} !== 4'b0) $display("FAIL rstmid_async: got busy/ce/ifack/dmack=%b required 0000", {a_busy, a_mem_ce, a_if_ack, a_dm_ack}); else passed++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++; if ({a_if_ack, a_dm_ack, a_busy} !== 3'b0) $display("FAIL rstmid_no_ack: cycle %0d got ifack/dmack/busy=%b required 000", k, {a_if_ack, a_dm_ack, a_busy}); else passed++;
            @(posedge clk);
            #1;
        end
        dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h200;
        q.push_back(mk(1'b1, 32'h5A5A_0200, 3));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_if_ack || a_dm_ack) begin
                total++;
                if (q.size() == 0) $display("FAIL rstmid_ack: unexpected ack at cycle %0d, required none", k);
                else begin
                    e = q.pop_front();
                    if (a_dm_ack !== e.dm || a_if_ack !== !e.dm || (e.dm ? a_dm_rdata : a_if_rdata) !== e.data || k != e.cyc)
                        $display("FAIL rstmid_ack: got dm=%0b data=%h cycle %0d, required dm=%0b data=%h cycle %0d", a_dm_ack, (e.dm ? a_dm_rdata : a_if_rdata), k, e.dm, e.data, e.cyc);
                    else passed++;
                end
                if (a_dm_ack) drop_dm = 1'b1;
            end
            @(posedge clk);
            #1;
            if (drop_dm) dm_req = 1'b0;
        end
        total++; if (q.size() != 0) $display("FAIL rstmid_pending: got %0d outstanding acks required 0", q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_write();
        test_lat1();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
